vending_machine_multi: RTL and testbench

Parametrised multi-product vending controller: next generation of the two-coin Rs.5/Rs.10 machine. Accumulates credit from two coin denominations, vends one of `NUM_PROD` products at per-product prices, and returns change or a cancelled credit as a timed sequence of coin pulses. Sits between the coin acceptor/keypad front end and the dispenser/change-hopper drivers.

---
 rtl/vending_machine_multi.sv | 126 ++++++++++++
 tb/tb_vending_machine_multi.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vending_machine_multi.sv
// Multi-product coin-operated vending controller: accumulates two coin
// denominations, vends at per-product prices and pays change as coin pulses.
module vending_machine_multi #(
  parameter int NUM_PROD   = 4,
  parameter int CREDIT_W   = 8,
  parameter int COIN_A     = 5,
  parameter int COIN_B     = 10,
  parameter int MAX_CREDIT = 100,
  parameter logic [NUM_PROD*CREDIT_W-1:0] PRICES = {8'd25, 8'd20, 8'd10, 8'd15},
  parameter int SEL_W      = (NUM_PROD > 1) ? $clog2(NUM_PROD) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                coin_valid,
  input  logic                coin_sel,
  input  logic                prod_req,
  input  logic [SEL_W-1:0]    prod_sel,
  input  logic                cancel,
  output logic                dispense,
  output logic [SEL_W-1:0]    dispense_id,
  output logic                chg_a,
  output logic                chg_b,
  output logic                coin_reject,
  output logic                deny,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit
);

  typedef enum logic [1:0] {ACCEPT, VEND, CHANGE} state_t;

  localparam logic [CREDIT_W-1:0] COIN_A_V = CREDIT_W'(COIN_A);
  localparam logic [CREDIT_W-1:0] COIN_B_V = CREDIT_W'(COIN_B);
  localparam logic [CREDIT_W:0]   MAX_V    = (CREDIT_W+1)'(MAX_CREDIT);

  state_t              state;
  logic [CREDIT_W-1:0] price;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_fits;
  logic                sel_ok;

  // One extra bit on the sum so the limit check sees the true total before commit.
  always_comb begin
    price = '0;
    for (int i = 0; i < NUM_PROD; i++) begin
      if (prod_sel == SEL_W'(i)) price = PRICES[i*CREDIT_W +: CREDIT_W];
    end
    sel_ok    = (32'(prod_sel) < 32'(NUM_PROD));
    coin_val  = coin_sel ? COIN_B_V : COIN_A_V;
    coin_sum  = {1'b0, credit} + {1'b0, coin_val};
    coin_fits = (coin_sum <= MAX_V);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ACCEPT;
      credit      <= '0;
      dispense    <= 1'b0;
      dispense_id <= '0;
      chg_a       <= 1'b0;
      chg_b       <= 1'b0;
      coin_reject <= 1'b0;
      deny        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      dispense    <= 1'b0;
      chg_a       <= 1'b0;
      chg_b       <= 1'b0;
      coin_reject <= 1'b0;
      deny        <= 1'b0;
      case (state)
        ACCEPT: begin
          if (cancel) begin
            coin_reject <= coin_valid;
            if (credit >= COIN_A_V) begin
              state <= CHANGE;
              busy  <= 1'b1;
            end
          end else if (prod_req) begin
            coin_reject <= coin_valid;
            if (!sel_ok || credit < price) begin
              deny <= 1'b1;
            end else begin
              credit      <= credit - price;
              dispense    <= 1'b1;
              dispense_id <= prod_sel;
              state       <= VEND;
              busy        <= 1'b1;
            end
          end else if (coin_valid) begin
            if (coin_fits) credit <= coin_sum[CREDIT_W-1:0];
            else           coin_reject <= 1'b1;
          end
        end
        VEND: begin
          coin_reject <= coin_valid;
          if (credit >= COIN_A_V) begin
            state <= CHANGE;
          end else begin
            state <= ACCEPT;
            busy  <= 1'b0;
          end
        end
        CHANGE: begin
          // Largest coin first; any residue below COIN_A stays as credit.
          coin_reject <= coin_valid;
          if (credit >= COIN_B_V) begin
            chg_b  <= 1'b1;
            credit <= credit - COIN_B_V;
          end else if (credit >= COIN_A_V) begin
            chg_a  <= 1'b1;
            credit <= credit - COIN_A_V;
          end else begin
            state <= ACCEPT;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ACCEPT;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vending_machine_multi.sv
// Directed bench for vending_machine_multi; a second 3-product build
// exercises out-of-range product selects.
module tb_vending_machine_multi;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       coin_valid = 1'b0, coin_sel = 1'b0, prod_req = 1'b0, cancel = 1'b0;
  logic [1:0] prod_sel = 2'd0;

  logic       dispense, chg_a, chg_b, coin_reject, deny, busy;
  logic [1:0] dispense_id;
  logic [7:0] credit;
  logic       d2_dispense, d2_chg_a, d2_chg_b, d2_coin_reject, d2_deny, d2_busy;
  logic [1:0] d2_dispense_id;
  logic [7:0] d2_credit;

  // flags order: dispense, chg_a, chg_b, coin_reject, deny, busy
  logic [5:0] flags, d2_flags;
  assign flags    = {dispense, chg_a, chg_b, coin_reject, deny, busy};
  assign d2_flags = {d2_dispense, d2_chg_a, d2_chg_b, d2_coin_reject, d2_deny, d2_busy};

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  vending_machine_multi dut (
    .clk(clk), .reset_n(reset_n), .coin_valid(coin_valid), .coin_sel(coin_sel),
    .prod_req(prod_req), .prod_sel(prod_sel), .cancel(cancel),
    .dispense(dispense), .dispense_id(dispense_id), .chg_a(chg_a), .chg_b(chg_b),
    .coin_reject(coin_reject), .deny(deny), .busy(busy), .credit(credit)
  );

  vending_machine_multi #(.NUM_PROD(3), .PRICES({8'd20, 8'd10, 8'd15})) dut3 (
    .clk(clk), .reset_n(reset_n), .coin_valid(coin_valid), .coin_sel(coin_sel),
    .prod_req(prod_req), .prod_sel(prod_sel), .cancel(cancel),
    .dispense(d2_dispense), .dispense_id(d2_dispense_id), .chg_a(d2_chg_a), .chg_b(d2_chg_b),
    .coin_reject(d2_coin_reject), .deny(d2_deny), .busy(d2_busy), .credit(d2_credit)
  );

  // Drive one cycle of inputs, let the edge take them, observe 1ns later.
  task automatic step(input logic cv, input logic cs, input logic pr,
                      input logic [1:0] ps, input logic cn);
    coin_valid = cv; coin_sel = cs; prod_req = pr; prod_sel = ps; cancel = cn;
    @(posedge clk); #1;
    coin_valid = 1'b0; coin_sel = 1'b0; prod_req = 1'b0; prod_sel = 2'd0; cancel = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    vectors++;
    if (flags !== 6'b0 || credit !== 8'd0) begin
      miscompares++;
      $display("[TB] FAIL reset: flags=%b credit=%0d, expected 000000 and 0", flags, credit);
    end
    @(negedge clk); reset_n = 1'b1;
    step(0, 0, 0, 0, 0);
    vectors++;
    if (flags !== 6'b0 || credit !== 8'd0) begin
      miscompares++;
      $display("[TB] FAIL idle_after_reset: flags=%b credit=%0d, expected 000000 and 0", flags, credit);
    end
  endtask

  task automatic test_vend_exact;
    step(1, 0, 0, 0, 0);
    vectors++;
    if (credit !== 8'd5 || flags !== 6'b0) begin
      miscompares++;
      $display("[TB] FAIL coin_a: credit=%0d flags=%b, expected 5 000000", credit, flags);
    end
    step(0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    vectors++;
    if (credit !== 8'd15) begin
      miscompares++;
      $display("[TB] FAIL coin_b: credit=%0d, expected 15", credit);
    end
    step(0, 0, 1, 0, 0);
    vectors++;
    if (flags !== 6'b100001 || credit !== 8'd0 || dispense_id !== 2'd0) begin
      miscompares++;
      $display("[TB] FAIL vend_exact: flags=%b credit=%0d id=%0d, expected 100001 0 0", flags, credit, dispense_id);
    end
    step(0, 0, 0, 0, 0);
    vectors++;
    if (flags !== 6'b0 || credit !== 8'd0) begin
      miscompares++;
      $display("[TB] FAIL vend_exact_done: flags=%b credit=%0d, expected 000000 0", flags, credit);
    end
  endtask

  task automatic test_vend_change;
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    vectors++;
    if (credit !== 8'd20) begin
      miscompares++;
      $display("[TB] FAIL credit_20: credit=%0d, expected 20", credit);
    end
    step(0, 0, 1, 0, 0);
    vectors++;
    if (flags !== 6'b100001 || credit !== 8'd5) begin
      miscompares++;
      $display("[TB] FAIL vend_k: flags=%b credit=%0d, expected 100001 5", flags, credit);
    end
    step(0, 0, 0, 0, 0);
    vectors++;
    if (flags !== 6'b000001 || credit !== 8'd5) begin
      miscompares++;
      $display("[TB] FAIL vend_k1: flags=%b credit=%0d, expected 000001 5", flags, credit);
    end
    step(0, 0, 0, 0, 0);
    vectors++;
    if (flags !== 6'b010001 || credit !== 8'd0) begin
      miscompares++;
      $display("[TB] FAIL vend_chg_a: flags=%b credit=%0d, expected 010001 0", flags, credit);
    end
    step(0, 0, 0, 0, 0);
    vectors++;
    if (flags !== 6'b0 || credit !== 8'd0) begin
      miscompares++;
      $display("[TB] FAIL vend_change_done: flags=%b credit=%0d, expected 000000 0", flags, credit);
    end
  endtask

  task automatic test_cancel;
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    vectors++;
    if (flags !== 6'b000001 || credit !== 8'd50) begin
      miscompares++;
      $display("[TB] FAIL cancel_k: flags=%b credit=%0d, expected 000001 50", flags, credit);
    end
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 0);
      vectors++;
      if (flags !== 6'b001001 || credit !== 8'(40 - 10 * i)) begin
        miscompares++;
        $display("[TB] FAIL cancel_pulse%0d: flags=%b credit=%0d, expected 001001 %0d", i, flags, credit, 40 - 10 * i);
      end
    end
    step(0, 0, 0, 0, 0);
    vectors++;
    if (flags !== 6'b0 || credit !== 8'd0) begin
      miscompares++;
      $display("[TB] FAIL cancel_done: flags=%b credit=%0d, expected 000000 0", flags, credit);
    end
    step(0, 0, 0, 0, 1);
    vectors++;
    if (flags !== 6'b0 || credit !== 8'd0) begin
      miscompares++;
      $display("[TB] FAIL cancel_empty: flags=%b credit=%0d, expected 000000 0", flags, credit);
    end
  endtask

  task automatic test_deny;
    step(1, 1, 0, 0, 0);
    step(0, 0, 1, 2'd2, 0);
    vectors++;
    if (flags !== 6'b000010 || credit !== 8'd10) begin
      miscompares++;
      $display("[TB] FAIL deny_price: flags=%b credit=%0d, expected 000010 10", flags, credit);
    end
    // select 7 truncates to 3 on a 2-bit bus
    step(0, 0, 1, 2'd3, 0);
    vectors++;
    if (flags !== 6'b000010 || credit !== 8'd10) begin
      miscompares++;
      $display("[TB] FAIL deny_sel7: flags=%b credit=%0d, expected 000010 10", flags, credit);
    end
    vectors++;
    if (d2_flags !== 6'b000010 || d2_credit !== 8'd10) begin
      miscompares++;
      $display("[TB] FAIL deny_range3: flags=%b credit=%0d, expected 000010 10", d2_flags, d2_credit);
    end
  endtask

  task automatic test_full_and_busy_coins;
    for (int i = 0; i < 9; i++) step(1, 1, 0, 0, 0);
    vectors++;
    if (credit !== 8'd100 || d2_credit !== 8'd100) begin
      miscompares++;
      $display("[TB] FAIL credit_100: credit=%0d/%0d, expected 100/100", credit, d2_credit);
    end
    step(1, 0, 0, 0, 0);
    vectors++;
    if (flags !== 6'b000100 || credit !== 8'd100) begin
      miscompares++;
      $display("[TB] FAIL full_reject: flags=%b credit=%0d, expected 000100 100", flags, credit);
    end
    step(0, 0, 1, 2'd3, 0);
    vectors++;
    if (flags !== 6'b100001 || credit !== 8'd75 || dispense_id !== 2'd3) begin
      miscompares++;
      $display("[TB] FAIL vend_p3: flags=%b credit=%0d id=%0d, expected 100001 75 3", flags, credit, dispense_id);
    end
    vectors++;
    if (d2_flags !== 6'b000010 || d2_credit !== 8'd100) begin
      miscompares++;
      $display("[TB] FAIL range3_full: flags=%b credit=%0d, expected 000010 100", d2_flags, d2_credit);
    end
    step(1, 0, 0, 0, 0);
    vectors++;
    if (flags !== 6'b000101 || credit !== 8'd75) begin
      miscompares++;
      $display("[TB] FAIL vend_coin: flags=%b credit=%0d, expected 000101 75", flags, credit);
    end
    for (int i = 0; i < 7; i++) begin
      step(i == 2, 1, 0, 0, 0);
      vectors++;
      if (flags !== ((i == 2) ? 6'b001101 : 6'b001001) || credit !== 8'(65 - 10 * i)) begin
        miscompares++;
        $display("[TB] FAIL chg75_b%0d: flags=%b credit=%0d, expected %b %0d", i, flags, credit,
                 (i == 2) ? 6'b001101 : 6'b001001, 65 - 10 * i);
      end
    end
    step(0, 0, 0, 0, 0);
    vectors++;
    if (flags !== 6'b010001 || credit !== 8'd0) begin
      miscompares++;
      $display("[TB] FAIL chg75_a: flags=%b credit=%0d, expected 010001 0", flags, credit);
    end
    step(0, 0, 0, 0, 0);
    vectors++;
    if (flags !== 6'b0 || credit !== 8'd0) begin
      miscompares++;
      $display("[TB] FAIL chg75_done: flags=%b credit=%0d, expected 000000 0", flags, credit);
    end
  endtask

  task automatic test_back_to_back;
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 1, 2'd1, 0);
    vectors++;
    if (flags !== 6'b100101 || credit !== 8'd10 || dispense_id !== 2'd1) begin
      miscompares++;
      $display("[TB] FAIL vend_plus_coin: flags=%b credit=%0d id=%0d, expected 100101 10 1", flags, credit, dispense_id);
    end
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    vectors++;
    if (flags !== 6'b001001 || credit !== 8'd0) begin
      miscompares++;
      $display("[TB] FAIL b2b_chg_b: flags=%b credit=%0d, expected 001001 0", flags, credit);
    end
    step(0, 0, 0, 0, 0);
    vectors++;
    if (flags !== 6'b0) begin
      miscompares++;
      $display("[TB] FAIL b2b_done: flags=%b, expected 000000", flags);
    end
  endtask

  task automatic test_reset_mid_change;
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    vectors++;
    if (flags !== 6'b001001 || credit !== 8'd10) begin
      miscompares++;
      $display("[TB] FAIL pre_reset_pulse: flags=%b credit=%0d, expected 001001 10", flags, credit);
    end
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if (flags !== 6'b0 || credit !== 8'd0 || dispense_id !== 2'd0) begin
      miscompares++;
      $display("[TB] FAIL async_reset: flags=%b credit=%0d id=%0d, expected 000000 0 0", flags, credit, dispense_id);
    end
    #2 reset_n = 1'b1;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    vectors++;
    if (flags !== 6'b0 || credit !== 8'd0) begin
      miscompares++;
      $display("[TB] FAIL post_reset: flags=%b credit=%0d, expected 000000 0", flags, credit);
    end
  endtask

  initial begin
    test_reset;
    test_vend_exact;
    test_vend_change;
    test_cancel;
    test_deny;
    test_full_and_busy_coins;
    test_back_to_back;
    test_reset_mid_change;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
